// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite constants and FSM state types
//
// Purpose: response codes, bus widths and the write/read channel FSM state
// encodings used by the register responder and its sub-modules.
// Ports: none (package).
package axi_lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_lite_slave_regs_if.sv
// rtl/axi_lite_slave_regs_if.sv - AXI4-Lite AW/W/B/AR/R channel bundle
//
// Purpose: groups the five AXI4-Lite channels into one port.
// Modports:
//   master - drives AW/W/AR payload+VALID and BREADY/RREADY
//   slave  - drives AWREADY/WREADY/ARREADY and the B/R responses
interface axi_lite_slave_regs_if #(
    parameter int ADDR_W = 8
) ();
    import axi_lite_pkg::*;

    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID,
        input  ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID,
        output ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - NUM_REGS x 32-bit register bank with byte strobes
//
// Purpose: storage for the AXI4-Lite responder.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset (clears all regs)
//   we_i           - commit write this edge (caller has already range-checked)
//   widx_i         - register index to write
//   wdata_i/wstrb_i- write data and byte-lane enables
//   ridx_i         - combinational read index
//   rdata_o        - contents of register ridx_i (0 if no such register)
//   regs_flat_o    - all registers, reg i at [32i+31:32i]
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we_i,
    input  logic [IDX_W-1:0]           widx_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [STRB_W-1:0]          wstrb_i,
    input  logic [IDX_W-1:0]           ridx_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [DATA_W*NUM_REGS-1:0] regs_flat_o
);

    // Read mux built as an OR chain so every select uses a constant index.
    logic [DATA_W-1:0] rd_chain [NUM_REGS+1];
    assign rd_chain[0] = '0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic [DATA_W-1:0] reg_q;
        logic              hit_w;

        assign hit_w = we_i && (widx_i == IDX_W'(g));

        for (genvar b = 0; b < STRB_W; b++) begin : g_lane
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    reg_q[8*b +: 8] <= '0;
                end else if (hit_w && wstrb_i[b]) begin
                    reg_q[8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end

        assign rd_chain[g+1] = rd_chain[g] | ((ridx_i == IDX_W'(g)) ? reg_q : '0);
        assign regs_flat_o[DATA_W*g +: DATA_W] = reg_q;
    end

    assign rdata_o = rd_chain[NUM_REGS];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite register responder, write and read FSMs
//
// Purpose: answers AXI4-Lite transactions against a bank of NUM_REGS 32-bit
// registers; one outstanding write and one outstanding read, independent.
// Ports:
//   ACLK, ARESETN - clock, asynchronous active-low reset
//   bus           - AXI4-Lite channels (slave modport)
//   regs_flat     - register contents, reg i at [32i+31:32i]
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    axi_lite_slave_regs_if.slave       bus,
    output logic [DATA_W*NUM_REGS-1:0] regs_flat
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

    // ---------------- write channel ----------------
    wr_state_e         wr_state_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [1:0]        bresp_q;
    logic              aw_done_q, w_done_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              aw_hs, w_hs, wr_fire, wr_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]  wr_idx;

    assign aw_hs = bus.AWVALID && awready_q;
    assign w_hs  = bus.WVALID && wready_q;

    // A channel captured on an earlier edge comes from its holding register,
    // one arriving this edge comes straight off the bus.
    assign wr_addr = aw_done_q ? awaddr_q : bus.AWADDR;
    assign wr_data = w_done_q  ? wdata_q  : bus.WDATA;
    assign wr_strb = w_done_q  ? wstrb_q  : bus.WSTRB;
    assign wr_idx  = wr_addr[ADDR_W-1:2];
    assign wr_ok   = {1'b0, wr_idx} < NUM_REGS_L;
    assign wr_fire = (wr_state_q == W_IDLE) && (aw_done_q || aw_hs) && (w_done_q || w_hs);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (wr_fire) begin
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        wr_state_q <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_done_q <= 1'b1;
                            awaddr_q  <= bus.AWADDR;
                        end
                        if (w_hs) begin
                            w_done_q <= 1'b1;
                            wdata_q  <= bus.WDATA;
                            wstrb_q  <= bus.WSTRB;
                        end
                        // Also raises the READYs on the first edge out of reset.
                        awready_q <= !(aw_done_q || aw_hs);
                        wready_q  <= !(w_done_q || w_hs);
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bvalid_q   <= 1'b0;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;

    // ---------------- read channel ----------------
    rd_state_e         rd_state_q;
    logic              arready_q, rvalid_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] rdata_q;

    logic [IDX_W-1:0]  rd_idx;
    logic              rd_ok;
    logic [DATA_W-1:0] rf_rdata;

    assign rd_idx = bus.ARADDR[ADDR_W-1:2];
    assign rd_ok  = {1'b0, rd_idx} < NUM_REGS_L;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (bus.ARVALID && arready_q) begin
                        // Register contents before any write committing this edge.
                        rdata_q    <= rd_ok ? rf_rdata : '0;
                        rresp_q    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.RREADY) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RDATA   = rdata_q;

    // Address bits [1:0] select a byte within a word and do not affect decode.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{wr_addr[1:0], bus.ARADDR[1:0]};

    axi_lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk_i       (ACLK),
        .rst_ni      (ARESETN),
        .we_i        (wr_fire && wr_ok),
        .widx_i      (wr_idx),
        .wdata_i     (wr_data),
        .wstrb_i     (wr_strb),
        .ridx_i      (rd_idx),
        .rdata_o     (rf_rdata),
        .regs_flat_o (regs_flat)
    );

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb/tb_axi_lite_slave_regs.sv - self-checking bench for axi_lite_slave_regs
module tb_axi_lite_slave_regs;
    import axi_lite_pkg::*;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [32*16-1:0] regs_flat;

    axi_lite_slave_regs_if #(.ADDR_W(8)) bus ();

    axi_lite_slave_regs #(.ADDR_W(8), .NUM_REGS(16)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .bus       (bus),
        .regs_flat (regs_flat)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [16];

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return regs_flat[32*i +: 32];
    endfunction

    task automatic mdl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [3:0] idx;
        idx = a[5:2];
        if (a[7:6] == 2'b00) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic issue_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_p, w_p, ta, tw;
        int n;
        aw_p = 1; w_p = 1; n = 0;
        bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        while ((aw_p || w_p) && n < 50) begin
            @(negedge ACLK);
            ta = aw_p && bus.AWREADY;
            tw = w_p && bus.WREADY;
            @(posedge ACLK); #1;
            if (ta) begin bus.AWVALID = 1'b0; aw_p = 0; end
            if (tw) begin bus.WVALID = 1'b0; w_p = 0; end
            n++;
        end
        chk("wr_handshake_done", 32'({aw_p, w_p}), 32'd0);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        mdl_write(a, d, s);
    endtask

    task automatic wait_b(output logic [1:0] resp, output int lat);
        lat = 0;
        @(negedge ACLK);
        while (!bus.BVALID && lat < 20) begin @(negedge ACLK); lat++; end
        resp = bus.BRESP;
    endtask

    task automatic ack_b();
        bus.BREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.BREADY = 1'b0;
    endtask

    task automatic issue_rd(input logic [7:0] a);
        bit p, t;
        int n;
        p = 1; n = 0;
        bus.ARADDR = a; bus.ARVALID = 1'b1;
        while (p && n < 50) begin
            @(negedge ACLK);
            t = bus.ARREADY;
            @(posedge ACLK); #1;
            if (t) begin bus.ARVALID = 1'b0; p = 0; end
            n++;
        end
        chk("rd_handshake_done", 32'(p), 32'd0);
        bus.ARVALID = 1'b0;
    endtask

    task automatic wait_r(output logic [31:0] data, output logic [1:0] resp, output int lat);
        lat = 0;
        @(negedge ACLK);
        while (!bus.RVALID && lat < 20) begin @(negedge ACLK); lat++; end
        data = bus.RDATA;
        resp = bus.RRESP;
    endtask

    task automatic ack_r();
        bus.RREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.RREADY = 1'b0;
    endtask

    task automatic do_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] exp_resp);
        logic [1:0] resp;
        int lat;
        issue_wr(a, d, s);
        wait_b(resp, lat);
        chk("bvalid_latency", lat, 0);
        chk("bresp", 32'(resp), 32'(exp_resp));
        ack_b();
    endtask

    task automatic do_rd(input logic [7:0] a, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] data;
        logic [1:0] resp;
        int lat;
        issue_rd(a);
        wait_r(data, resp, lat);
        chk("rvalid_latency", lat, 0);
        chk("rdata", data, exp_data);
        chk("rresp", 32'(resp), 32'(exp_resp));
        ack_r();
    endtask

    task automatic chk_all_regs(input string name);
        for (int i = 0; i < 16; i++) chk(name, reg_of(i), mdl[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [1:0] resp;
        logic [31:0] data;
        int lat;

        bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
        bus.BREADY = 0; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;

        //            wr    addr   data          strb    resp    rdata
        vt[0]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vt[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 8'h08, 32'hAABBCCDD, 4'hF, 2'b00, 32'h0};
        vt[3]  = '{1'b1, 8'h3C, 32'h12345678, 4'hF, 2'b00, 32'h0};
        vt[4]  = '{1'b0, 8'h3C, 32'h0,        4'h0, 2'b00, 32'h12345678};
        vt[5]  = '{1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
        vt[6]  = '{1'b0, 8'h10, 32'h0,        4'h0, 2'b00, 32'h0};
        vt[7]  = '{1'b1, 8'h07, 32'hCAFE0000, 4'hC, 2'b00, 32'h0};
        vt[8]  = '{1'b0, 8'h05, 32'h0,        4'h0, 2'b00, 32'hCAFEBEEF};
        vt[9]  = '{1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
        vt[10] = '{1'b0, 8'h40, 32'h0,        4'h0, 2'b10, 32'h0};
        vt[11] = '{1'b0, 8'hFC, 32'h0,        4'h0, 2'b10, 32'h0};

        // Reset state
        #12;
        chk("rst_awready", 32'(bus.AWREADY), 0);
        chk("rst_wready",  32'(bus.WREADY),  0);
        chk("rst_arready", 32'(bus.ARREADY), 0);
        chk("rst_bvalid",  32'(bus.BVALID),  0);
        chk("rst_rvalid",  32'(bus.RVALID),  0);
        chk("rst_bresp",   32'(bus.BRESP),   0);
        chk("rst_rresp",   32'(bus.RRESP),   0);
        chk("rst_rdata",   bus.RDATA,        0);
        chk_all_regs("rst_regs");
        @(negedge ACLK); ARESETN = 1'b1;
        #1;
        chk("rel_awready_before_edge", 32'(bus.AWREADY), 0);
        @(posedge ACLK); #1;
        chk("rel_awready", 32'(bus.AWREADY), 1);
        chk("rel_wready",  32'(bus.WREADY),  1);
        chk("rel_arready", 32'(bus.ARREADY), 1);

        // Table-driven single transactions
        for (int i = 0; i < 12; i++) begin
            if (vt[i].is_wr) do_wr(vt[i].addr, vt[i].data, vt[i].strb, vt[i].exp_resp);
            else             do_rd(vt[i].addr, vt[i].exp_rdata, vt[i].exp_resp);
        end
        chk_all_regs("table_regs");

        // W three cycles ahead of AW, partial strobes
        bus.WDATA = 32'h11223344; bus.WSTRB = 4'b0101; bus.WVALID = 1'b1;
        @(negedge ACLK);
        chk("wfirst_wready_hi", 32'(bus.WREADY), 1);
        @(posedge ACLK); #1; bus.WVALID = 1'b0;
        repeat (3) begin
            @(negedge ACLK);
            chk("wfirst_wready_lo",  32'(bus.WREADY),  0);
            chk("wfirst_awready_hi", 32'(bus.AWREADY), 1);
            chk("wfirst_no_bvalid",  32'(bus.BVALID),  0);
            chk("wfirst_no_commit",  reg_of(2), 32'hAABBCCDD);
        end
        @(posedge ACLK); #1;
        bus.AWADDR = 8'h08; bus.AWVALID = 1'b1;
        @(negedge ACLK);
        chk("wfirst_awready", 32'(bus.AWREADY), 1);
        @(posedge ACLK); #1; bus.AWVALID = 1'b0;
        @(negedge ACLK);
        chk("wfirst_bvalid", 32'(bus.BVALID), 1);
        chk("wfirst_bresp",  32'(bus.BRESP),  0);
        chk("wfirst_commit", reg_of(2), 32'hAA22CC44);
        ack_b();
        mdl_write(8'h08, 32'h11223344, 4'b0101);
        do_rd(8'h08, 32'hAA22CC44, RESP_OKAY);

        // Back-pressure on B, then on R
        issue_wr(8'h0C, 32'h000000A5, 4'hF);
        wait_b(resp, lat);
        chk("bstall_latency", lat, 0);
        repeat (5) begin
            chk("bstall_bvalid",  32'(bus.BVALID),  1);
            chk("bstall_bresp",   32'(bus.BRESP),   0);
            chk("bstall_awready", 32'(bus.AWREADY), 0);
            chk("bstall_wready",  32'(bus.WREADY),  0);
            @(negedge ACLK);
        end
        ack_b();
        chk("bstall_bvalid_clr", 32'(bus.BVALID),  0);
        chk("bstall_awready_hi", 32'(bus.AWREADY), 1);
        chk("bstall_wready_hi",  32'(bus.WREADY),  1);
        issue_rd(8'h0C);
        wait_r(data, resp, lat);
        chk("rstall_latency", lat, 0);
        repeat (5) begin
            chk("rstall_rvalid",  32'(bus.RVALID),  1);
            chk("rstall_rdata",   bus.RDATA,        32'h000000A5);
            chk("rstall_rresp",   32'(bus.RRESP),   0);
            chk("rstall_arready", 32'(bus.ARREADY), 0);
            @(negedge ACLK);
        end
        ack_r();
        chk("rstall_rvalid_clr", 32'(bus.RVALID),  0);
        chk("rstall_arready_hi", 32'(bus.ARREADY), 1);

        // Read and write of the same register on the same edge
        do_wr(8'h0C, 32'h1, 4'hF, RESP_OKAY);
        bus.AWADDR = 8'h0C; bus.WDATA = 32'h2; bus.WSTRB = 4'hF;
        bus.ARADDR = 8'h0C;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
        @(negedge ACLK);
        chk("same_awready", 32'(bus.AWREADY), 1);
        chk("same_wready",  32'(bus.WREADY),  1);
        chk("same_arready", 32'(bus.ARREADY), 1);
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        @(negedge ACLK);
        chk("same_bvalid", 32'(bus.BVALID), 1);
        chk("same_rvalid", 32'(bus.RVALID), 1);
        chk("same_rdata_old", bus.RDATA, 32'h1);
        chk("same_commit", reg_of(3), 32'h2);
        ack_b();
        ack_r();
        mdl_write(8'h0C, 32'h2, 4'hF);
        do_rd(8'h0C, 32'h2, RESP_OKAY);
        chk_all_regs("pre_reset_regs");

        // Reset while a write response is pending
        issue_wr(8'h00, 32'h5, 4'hF);
        wait_b(resp, lat);
        chk("rstmid_bvalid", 32'(bus.BVALID), 1);
        chk("rstmid_reg0",   reg_of(0), 32'h5);
        #2; ARESETN = 1'b0;
        #1;
        chk("rstmid_bvalid_clr", 32'(bus.BVALID),  0);
        chk("rstmid_reg0_clr",   reg_of(0),        0);
        chk("rstmid_awready",    32'(bus.AWREADY), 0);
        chk("rstmid_arready",    32'(bus.ARREADY), 0);
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        @(negedge ACLK); ARESETN = 1'b1;
        #1;
        chk("rstmid_wready_before_edge", 32'(bus.WREADY), 0);
        @(posedge ACLK); #1;
        chk("rstmid_awready_hi", 32'(bus.AWREADY), 1);
        chk("rstmid_wready_hi",  32'(bus.WREADY),  1);
        chk("rstmid_arready_hi", 32'(bus.ARREADY), 1);
        chk("rstmid_no_bvalid",  32'(bus.BVALID),  0);
        chk_all_regs("post_reset_regs");
        do_wr(8'h14, 32'h5A5A5A5A, 4'hF, RESP_OKAY);
        do_rd(8'h14, 32'h5A5A5A5A, RESP_OKAY);
        do_rd(8'h00, 32'h0, RESP_OKAY);
        chk_all_regs("final_regs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
